// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache controller codes (proc status, list commands, lookup status, fetch commands)
package cache_pkg;

    // Progress reported to the peer controller over proc_status_*
    localparam logic [2:0] PROC_NONE  = 3'b000;
    localparam logic [2:0] PROC_CHECK = 3'b001;
    localparam logic [2:0] PROC_BUSY  = 3'b010;
    localparam logic [2:0] PROC_DONE  = 3'b011;

    // Commands to the tag/allocation list
    localparam logic [1:0] ACC_CMD_NONE  = 2'b00;
    localparam logic [1:0] ACC_CMD_READ  = 2'b01;
    localparam logic [1:0] ACC_CMD_ALLOC = 2'b10;
    localparam logic [1:0] ACC_CMD_DONE  = 2'b11;

    // Lookup results returned by the list
    localparam logic [2:0] ACC_ST_MISS_CLEAN = 3'b000;
    localparam logic [2:0] ACC_ST_HIT_A      = 3'b001;
    localparam logic [2:0] ACC_ST_HIT_B      = 3'b010;
    localparam logic [2:0] ACC_ST_MISS_DIRTY = 3'b100;

    // Commands to the line fetcher
    localparam logic [1:0] FETCH_NONE = 2'b00;
    localparam logic [1:0] FETCH_ONLY = 2'b01;
    localparam logic [1:0] FETCH_WB   = 2'b10;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_MEM_DATA,
        RD_CHECK_CONFLICT,
        RD_WAIT_CONFLICT,
        RD_ALLOCATE_LINE,
        RD_FETCH_REQ,
        RD_WAIT_FETCH,
        RD_ACC_MEM
    } rd_state_t;

    function automatic logic is_hit(input logic [2:0] status);
        return (status == ACC_ST_HIT_A) || (status == ACC_ST_HIT_B);
    endfunction

    // Any code other than the two hits and the dirty miss is a clean miss.
    function automatic logic [1:0] miss_fetch_cmd(input logic [2:0] status);
        return (status == ACC_ST_MISS_DIRTY) ? FETCH_WB : FETCH_ONLY;
    endfunction

endpackage

// File: rtl/rd_ctrl.sv
// rtl/rd_ctrl.sv - cache read controller: lookup, hit read, miss allocate/fetch, writer conflict handling
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   acc_rd_*                      core read request / registered response
//   acc_index/status/cmd/tag/req  tag/allocation list interface, return_tag back
//   allocate_busy                 list allocator stall
//   proc_*_w / proc_*_r           progress exchange with the write controller
//   fetch_*                       line fetch request and completion
//   mem_raddr/ren/rdata           line memory read port (data one cycle after ren)
module rd_ctrl
    import cache_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         acc_rd_valid,
    output logic                                         acc_rd_ready,
    input  logic [addr_width-1:0]                        acc_rd_addr,
    output logic                                         acc_rd_rvalid,
    output logic [data_width-1:0]                        acc_rd_rdata,
    output logic [addr_width-1:0]                        acc_index,
    input  logic [2:0]                                   acc_status,
    output logic [1:0]                                   acc_cmd,
    output logic [$clog2(list_depth)-1:0]                acc_tag,
    input  logic [$clog2(list_depth)-1:0]                return_tag,
    output logic                                         acc_req,
    input  logic                                         allocate_busy,
    output logic [2:0]                                   proc_status_w,
    output logic [addr_width-1:0]                        proc_addr_w,
    output logic [$clog2(list_depth)-1:0]                proc_tag_w,
    input  logic [2:0]                                   proc_status_r,
    input  logic [addr_width-1:0]                        proc_addr_r,
    input  logic [$clog2(list_depth)-1:0]                proc_tag_r,
    output logic [1:0]                                   fetch_cmd,
    output logic                                         fetch_req,
    output logic [$clog2(list_depth)-1:0]                fetch_tag,
    output logic [addr_width-1:0]                        fetch_addr,
    input  logic                                         fetch_gnt,
    input  logic                                         fetch_done,
    output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
    output logic                                         mem_ren,
    input  logic [data_width-1:0]                        mem_rdata
);

    localparam int TAG_W  = $clog2(list_depth);
    localparam int WORD_W = $clog2(list_width);
    localparam int OFS_W  = $clog2(list_width * data_width / 8);
    localparam int BYTE_W = $clog2(data_width / 8);

    rd_state_t              r_state;
    rd_state_t              w_state_next;
    logic [addr_width-1:0]  r_addr;
    logic [TAG_W-1:0]       r_tag;
    logic [1:0]             r_fetch_cmd;
    logic [data_width-1:0]  r_rdata;
    logic                   r_rvalid;

    logic                   w_handshake;
    logic [addr_width-1:0]  w_addr;
    logic [addr_width-1:0]  w_line_addr;
    logic [WORD_W-1:0]      w_word;
    logic                   w_latch_tag;
    logic [TAG_W-1:0]       w_tag_in;
    logic                   w_set_fetch;
    logic                   w_capture;
    logic                   w_acc_req;
    logic [1:0]             w_acc_cmd;
    logic [TAG_W-1:0]       w_acc_tag;
    logic [2:0]             w_proc_status;
    logic [TAG_W-1:0]       w_proc_tag;
    logic                   w_fetch_req;
    logic                   w_mem_ren;
    logic [TAG_W+WORD_W-1:0] w_mem_raddr;
    logic                   w_unused;

    // The request address is used live in the handshake cycle so the lookup
    // and a hit read can start without waiting for the address register.
    assign w_handshake = (r_state == RD_IDLE) && acc_rd_valid;
    assign w_addr      = w_handshake ? acc_rd_addr : r_addr;
    assign w_line_addr = {w_addr[addr_width-1:OFS_W], {OFS_W{1'b0}}};
    assign w_word      = w_addr[OFS_W-1:BYTE_W];

    // Byte-within-word bits never select anything.
    assign w_unused = ^{acc_rd_addr[BYTE_W-1:0], r_addr[BYTE_W-1:0]};

    always_comb begin
        w_state_next  = r_state;
        w_latch_tag   = 1'b0;
        w_tag_in      = '0;
        w_set_fetch   = 1'b0;
        w_capture     = 1'b0;
        w_acc_req     = 1'b0;
        w_acc_cmd     = ACC_CMD_NONE;
        w_acc_tag     = '0;
        w_proc_status = PROC_NONE;
        w_proc_tag    = r_tag;
        w_fetch_req   = 1'b0;
        w_mem_ren     = 1'b0;
        w_mem_raddr   = '0;

        case (r_state)
            RD_IDLE: begin
                if (acc_rd_valid) begin
                    w_acc_req = 1'b1;
                    w_acc_cmd = ACC_CMD_READ;
                    if (is_hit(acc_status)) begin
                        w_mem_ren    = 1'b1;
                        w_mem_raddr  = {return_tag, w_word};
                        w_latch_tag  = 1'b1;
                        w_tag_in     = return_tag;
                        w_state_next = RD_MEM_DATA;
                    end else begin
                        w_state_next = RD_CHECK_CONFLICT;
                    end
                end
            end

            RD_MEM_DATA: begin
                w_capture    = 1'b1;
                w_state_next = RD_IDLE;
            end

            RD_CHECK_CONFLICT: begin
                w_proc_status = PROC_CHECK;
                // Writer is already filling this very line: reuse its fill.
                if ((proc_status_r == PROC_BUSY) && (proc_addr_r == w_line_addr))
                    w_state_next = RD_WAIT_CONFLICT;
                else
                    w_state_next = RD_ALLOCATE_LINE;
            end

            RD_WAIT_CONFLICT: begin
                w_proc_status = PROC_CHECK;
                if (proc_status_r == PROC_DONE) begin
                    w_latch_tag  = 1'b1;
                    w_tag_in     = proc_tag_r;
                    w_state_next = RD_ACC_MEM;
                end
            end

            RD_ALLOCATE_LINE: begin
                w_proc_status = PROC_BUSY;
                if (!allocate_busy) begin
                    w_acc_req    = 1'b1;
                    w_acc_cmd    = ACC_CMD_ALLOC;
                    w_latch_tag  = 1'b1;
                    w_tag_in     = return_tag;
                    w_proc_tag   = return_tag;
                    w_set_fetch  = 1'b1;
                    w_state_next = RD_FETCH_REQ;
                end
            end

            RD_FETCH_REQ: begin
                w_proc_status = PROC_BUSY;
                w_fetch_req   = 1'b1;
                if (fetch_gnt)
                    w_state_next = RD_WAIT_FETCH;
            end

            RD_WAIT_FETCH: begin
                w_proc_status = PROC_BUSY;
                if (fetch_done)
                    w_state_next = RD_ACC_MEM;
            end

            RD_ACC_MEM: begin
                w_mem_ren     = 1'b1;
                w_mem_raddr   = {r_tag, w_word};
                w_acc_req     = 1'b1;
                w_acc_cmd     = ACC_CMD_DONE;
                w_acc_tag     = r_tag;
                w_proc_status = PROC_DONE;
                w_state_next  = RD_MEM_DATA;
            end

            default: w_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RD_IDLE;
            r_addr      <= '0;
            r_tag       <= '0;
            r_fetch_cmd <= FETCH_NONE;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_capture;
            if (w_handshake)
                r_addr <= acc_rd_addr;
            if (w_latch_tag)
                r_tag <= w_tag_in;
            if (w_set_fetch)
                r_fetch_cmd <= miss_fetch_cmd(acc_status_q_sel(w_set_fetch));
            if (w_capture)
                r_rdata <= mem_rdata;
        end
    end

    // Miss type is recorded at lookup time; acc_status is only meaningful
    // in the handshake cycle, so keep it until the allocate grant.
    logic [2:0] r_miss_status;

    always_ff @(posedge clk) begin
        if (rst)
            r_miss_status <= ACC_ST_MISS_CLEAN;
        else if (w_handshake)
            r_miss_status <= acc_status;
    end

    function automatic logic [2:0] acc_status_q_sel(input logic sel);
        return sel ? r_miss_status : ACC_ST_MISS_CLEAN;
    endfunction

    assign acc_rd_ready  = (r_state == RD_IDLE);
    assign acc_rd_rvalid = r_rvalid;
    assign acc_rd_rdata  = r_rdata;
    assign acc_index     = w_line_addr;
    assign acc_cmd       = w_acc_cmd;
    assign acc_tag       = w_acc_tag;
    assign acc_req       = w_acc_req;
    assign proc_status_w = w_proc_status;
    assign proc_addr_w   = w_line_addr;
    assign proc_tag_w    = w_proc_tag;
    assign fetch_cmd     = r_fetch_cmd;
    assign fetch_req     = w_fetch_req;
    assign fetch_tag     = r_tag;
    assign fetch_addr    = w_line_addr;
    assign mem_raddr     = w_mem_raddr;
    assign mem_ren       = w_mem_ren;

endmodule

// File: tb/tb_rd_ctrl.sv
// tb/tb_rd_ctrl.sv - directed self-checking bench for rd_ctrl
module tb_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_rd_valid;
    logic        acc_rd_ready;
    logic [31:0] acc_rd_addr;
    logic        acc_rd_rvalid;
    logic [31:0] acc_rd_rdata;
    logic [31:0] acc_index;
    logic [2:0]  acc_status;
    logic [1:0]  acc_cmd;
    logic [1:0]  acc_tag;
    logic [1:0]  return_tag;
    logic        acc_req;
    logic        allocate_busy;
    logic [2:0]  proc_status_w;
    logic [31:0] proc_addr_w;
    logic [1:0]  proc_tag_w;
    logic [2:0]  proc_status_r;
    logic [31:0] proc_addr_r;
    logic [1:0]  proc_tag_r;
    logic [1:0]  fetch_cmd;
    logic        fetch_req;
    logic [1:0]  fetch_tag;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_done;
    logic [6:0]  mem_raddr;
    logic        mem_ren;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rd_ctrl dut (
        .clk(clk), .rst(rst),
        .acc_rd_valid(acc_rd_valid), .acc_rd_ready(acc_rd_ready), .acc_rd_addr(acc_rd_addr),
        .acc_rd_rvalid(acc_rd_rvalid), .acc_rd_rdata(acc_rd_rdata),
        .acc_index(acc_index), .acc_status(acc_status), .acc_cmd(acc_cmd), .acc_tag(acc_tag),
        .return_tag(return_tag), .acc_req(acc_req), .allocate_busy(allocate_busy),
        .proc_status_w(proc_status_w), .proc_addr_w(proc_addr_w), .proc_tag_w(proc_tag_w),
        .proc_status_r(proc_status_r), .proc_addr_r(proc_addr_r), .proc_tag_r(proc_tag_r),
        .fetch_cmd(fetch_cmd), .fetch_req(fetch_req), .fetch_tag(fetch_tag), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
        .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and
    // outputs sampled 1 time unit later, well away from either edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; acc_rd_valid = 1'b0; acc_rd_addr = '0; acc_status = '0; return_tag = '0;
        allocate_busy = 1'b0; proc_status_r = '0; proc_addr_r = '0; proc_tag_r = '0;
        fetch_gnt = 1'b0; fetch_done = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        check("rst_ready", acc_rd_ready, 1);
        check("rst_rvalid", acc_rd_rvalid, 0);
        check("rst_req", acc_req, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_pstat", proc_status_w, 0);
        check("rst_index", acc_index, 0);
        check("rst_fetch_cmd", fetch_cmd, 0);

        // ---------------- hit ----------------
        cyc();
        acc_rd_valid = 1'b1; acc_rd_addr = 32'h0000_0044; acc_status = 3'b001; return_tag = 2'd2;
        settle();
        check("hit_req", acc_req, 1);
        check("hit_cmd", acc_cmd, 2'b01);
        check("hit_ren", mem_ren, 1);
        check("hit_raddr", mem_raddr, 7'h51);
        cyc();
        acc_rd_valid = 1'b0; acc_status = 3'b000; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("hit_busy_ready", acc_rd_ready, 0);
        check("hit_rvalid_early", acc_rd_rvalid, 0);
        cyc();
        mem_rdata = 32'h0BAD_0BAD;
        settle();
        check("hit_rvalid", acc_rd_rvalid, 1);
        check("hit_rdata", acc_rd_rdata, 32'hDEAD_BEEF);
        cyc();
        check("hit_rvalid_pulse", acc_rd_rvalid, 0);

        // ---------------- clean miss ----------------
        acc_rd_valid = 1'b1; acc_rd_addr = 32'h0000_1234; acc_status = 3'b000;
        allocate_busy = 1'b1; return_tag = 2'd1;
        settle();
        check("cm_lookup_cmd", acc_cmd, 2'b01);
        check("cm_no_ren", mem_ren, 0);
        check("cm_index", acc_index, 32'h0000_1200);
        cyc();
        acc_rd_valid = 1'b0; acc_rd_addr = 32'hFFFF_FFFF;
        settle();
        check("cm_check_pstat", proc_status_w, 3'b001);
        check("cm_index_held", acc_index, 32'h0000_1200);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("cm_busy_noreq", acc_req, 0);
            check("cm_busy_pstat", proc_status_w, 3'b010);
        end
        allocate_busy = 1'b0;
        settle();
        check("cm_alloc_req", acc_req, 1);
        check("cm_alloc_cmd", acc_cmd, 2'b10);
        check("cm_alloc_ptag", proc_tag_w, 2'd1);
        cyc();
        check("cm_freq", fetch_req, 1);
        check("cm_fcmd", fetch_cmd, 2'b01);
        check("cm_ftag", fetch_tag, 2'd1);
        check("cm_faddr", fetch_addr, 32'h0000_1200);
        cyc();
        check("cm_freq_hold", fetch_req, 1);
        fetch_gnt = 1'b1;
        cyc();
        fetch_gnt = 1'b0;
        settle();
        check("cm_wait_freq", fetch_req, 0);
        check("cm_wait_pstat", proc_status_w, 3'b010);
        cyc();
        fetch_done = 1'b1;
        cyc();
        fetch_done = 1'b0;
        settle();
        check("cm_done_req", acc_req, 1);
        check("cm_done_cmd", acc_cmd, 2'b11);
        check("cm_done_tag", acc_tag, 2'd1);
        check("cm_done_pstat", proc_status_w, 3'b011);
        check("cm_done_raddr", mem_raddr, 7'h2D);
        cyc();
        mem_rdata = 32'h1111_2222;
        settle();
        check("cm_md_pstat", proc_status_w, 3'b000);
        check("cm_md_acctag", acc_tag, 2'd0);
        cyc();
        check("cm_rvalid", acc_rd_rvalid, 1);
        check("cm_rdata", acc_rd_rdata, 32'h1111_2222);

        // ---------------- dirty miss ----------------
        cyc();
        acc_rd_valid = 1'b1; acc_rd_addr = 32'h0000_2080; acc_status = 3'b100; return_tag = 2'd3;
        cyc();
        acc_rd_valid = 1'b0; acc_status = 3'b000;
        cyc();
        settle();
        check("dm_alloc_cmd", acc_cmd, 2'b10);
        cyc();
        check("dm_fcmd", fetch_cmd, 2'b10);
        check("dm_faddr", fetch_addr, 32'h0000_2080);
        fetch_gnt = 1'b1;
        cyc();
        fetch_gnt = 1'b0; fetch_done = 1'b1;
        cyc();
        fetch_done = 1'b0;
        settle();
        check("dm_raddr", mem_raddr, 7'h60);
        check("dm_acctag", acc_tag, 2'd3);
        cyc();
        mem_rdata = 32'h3333_4444;
        cyc();
        check("dm_rvalid", acc_rd_rvalid, 1);
        check("dm_rdata", acc_rd_rdata, 32'h3333_4444);

        // ---------------- conflict with writer ----------------
        cyc();
        acc_rd_valid = 1'b1; acc_rd_addr = 32'h0000_3008; acc_status = 3'b000; return_tag = 2'd0;
        proc_status_r = 3'b010; proc_addr_r = 32'h0000_3000;
        cyc();
        acc_rd_valid = 1'b0;
        settle();
        check("cf_check_pstat", proc_status_w, 3'b001);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("cf_wait_noreq", acc_req, 0);
            check("cf_wait_nofetch", fetch_req, 0);
        end
        proc_status_r = 3'b011; proc_tag_r = 2'd3;
        cyc();
        proc_status_r = 3'b000; proc_tag_r = 2'd0;
        settle();
        check("cf_ren", mem_ren, 1);
        check("cf_raddr", mem_raddr, 7'h62);
        check("cf_acctag", acc_tag, 2'd3);
        cyc();
        mem_rdata = 32'h5555_6666;
        cyc();
        check("cf_rvalid", acc_rd_rvalid, 1);
        check("cf_rdata", acc_rd_rdata, 32'h5555_6666);

        // ---------------- reset during WAIT_FETCH ----------------
        cyc();
        acc_rd_valid = 1'b1; acc_rd_addr = 32'h0000_4000; acc_status = 3'b000; return_tag = 2'd2;
        cyc();
        acc_rd_valid = 1'b0;
        cyc();
        cyc();
        fetch_gnt = 1'b1;
        cyc();
        fetch_gnt = 1'b0;
        settle();
        check("rs_in_wait", proc_status_w, 3'b010);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("rs_ready", acc_rd_ready, 1);
        check("rs_pstat", proc_status_w, 3'b000);
        check("rs_fcmd", fetch_cmd, 2'b00);
        fetch_done = 1'b1;
        cyc();
        fetch_done = 1'b0;
        settle();
        check("rs_no_ren", mem_ren, 0);
        check("rs_no_req", acc_req, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rs_no_rvalid", acc_rd_rvalid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rd_ctrl.md
Name: rd_ctrl

Overview: Read-side controller of the cache, the counterpart of the write controller. It accepts core read requests, looks them up through the shared tag/allocation list, and returns hit data from line memory. On a miss it allocates a line, requests a fetch and returns the fetched word. It coordinates with the write controller through the proc status/addr/tag exchange so both never fill the same line.

Parameters:
addr_width, 32, byte-address width
list_depth, 4, number of cache lines (tag width = $clog2(list_depth))
data_width, 32, word width
list_width, 32, words per line (offset width = $clog2(list_width*data_width/8))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
acc_rd_valid  in  1  read request valid
acc_rd_ready  out  1  read request accepted; high only in IDLE
acc_rd_addr  in  addr_width  read byte address
acc_rd_rvalid  out  1  one-cycle pulse, read data valid; requester must accept
acc_rd_rdata  out  data_width  read data, registered
acc_index  out  addr_width  line-aligned lookup address (= proc_addr_w)
acc_status  in  3  lookup result: 001/010 hit; 000 miss clean victim; 100 miss dirty victim; others treated as 000
acc_cmd  out  2  01 read lookup, 10 allocate, 11 access complete
acc_tag  out  $clog2(list_depth)  tag for cmd 11, else 0
return_tag  in  $clog2(list_depth)  hit/allocated line tag
acc_req  out  1  list command strobe
allocate_busy  in  1  allocator cannot serve this cycle
proc_status_w  out  3  own progress: 000 none, 001 check, 010 busy, 011 done
proc_addr_w  out  addr_width  own line address {addr[aw-1:ofs], 0}
proc_tag_w  out  $clog2(list_depth)  own line tag
proc_status_r  in  3  write-controller progress
proc_addr_r  in  addr_width  write-controller line address
proc_tag_r  in  $clog2(list_depth)  write-controller line tag
fetch_cmd  out  2  01 fetch only, 10 writeback victim then fetch; registered
fetch_req  out  1  fetch request
fetch_tag  out  $clog2(list_depth)  target line tag
fetch_addr  out  addr_width  line address to fetch
fetch_gnt  in  1  fetch accepted
fetch_done  in  1  one-cycle pulse, line filled
mem_raddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, addr[ofs-1:2]}
mem_ren  out  1  line-memory read strobe; memory always accepts, data valid next cycle
mem_rdata  in  data_width  read data, one cycle after mem_ren

Behaviour:
- Reset: state IDLE; all registers and outputs 0 except acc_rd_ready=1. A mid-operation reset abandons the request; no response is issued.
- On a handshake, addr is registered; the outputs use the live addr in that cycle and the registered addr afterwards. acc_req=1 with cmd 01 in the handshake cycle.
- IDLE: on a handshake with a hit, drive mem_ren with {return_tag, offset}, latch return_tag, go MEM_DATA. On a miss (000/100), go CHECK_CONFLICT.
- MEM_DATA: capture mem_rdata into acc_rd_rdata, pulse acc_rd_rvalid, go IDLE. Hit latency: rvalid two cycles after the handshake edge.
- CHECK_CONFLICT: proc_status_w=001. If proc_status_r==010 and proc_addr_r==proc_addr_w, go WAIT_CONFLICT; else go ALLOCATE_LINE.
- WAIT_CONFLICT: hold until proc_status_r==011, then latch proc_tag_r and go ACC_MEM (the line is already being filled by the writer).
- ALLOCATE_LINE: proc_status_w=010. When !allocate_busy: acc_req with cmd 10, latch return_tag, set fetch_cmd (000->01, 100->10), go FETCH_REQ.
- FETCH_REQ: fetch_req=1 until fetch_gnt, then WAIT_FETCH. WAIT_FETCH: on fetch_done go ACC_MEM. Both states drive proc_status_w=010.
- ACC_MEM: mem_ren with the latched tag; acc_req with cmd 11 and acc_tag=latched tag; proc_status_w=011 for exactly this cycle; go MEM_DATA.
- proc_tag_w is return_tag in the ALLOCATE_LINE grant cycle, else the latched tag. fetch_addr=proc_addr_w; fetch_tag=latched tag.

Decomposition: Package cache_pkg holds the proc-status codes, the acc_cmd codes, the acc_status codes and the fetch_cmd codes, shared with the write controller. No sub-module.

Test Plan:
- Hit: addr 0x0000_0044, status 001, return_tag 2 -> mem_raddr {2,5'd17}; rvalid two cycles later with mem_rdata.
- Clean miss: status 000, allocate_busy high 3 cycles, return_tag 1 -> cmd 10 in cycle 4, fetch_cmd 01, fetch_req held until gnt; after fetch_done, cmd 11 with acc_tag 1, then data.
- Dirty miss: status 100 -> fetch_cmd 10, remainder as the clean-miss case.
- Conflict: proc_status_r 010 with matching proc_addr_r -> no allocate; at 011 with proc_tag_r 3 -> mem_raddr tag 3, data returned.
- Reset during WAIT_FETCH -> IDLE next cycle, acc_rd_ready=1, no rvalid issued.
